// File: rtl/tile_cache_2way.sv
// Two-way set-associative read-only cache between a tile fetch unit and a ROM port.
// LRU replacement, synchronous flush, saturating hit/miss counters, registered outputs.
module tile_cache_2way #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_valid,
  output logic [DATA_W-1:0] cache_data,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_valid,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [2:0]        dbg_state
);

  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int SETS  = 2 ** IDX_W;

  // Handshake: the requester holds cache_req and a stable cache_addr until cache_valid;
  // cache_valid stays high while the same request is held, and the next request is
  // sampled one cycle after the return to IDLE. rom_req is a level held until rom_valid.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CMP  = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                cache_valid_q, cache_valid_d;
  logic [DATA_W-1:0]   cache_data_q, cache_data_d;
  logic                rom_req_q, rom_req_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;
  logic                flush_seen_q;

  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     lru_q;

  logic [TAG_W-1:0]    tag_mem  [2][SETS];
  logic [DATA_W-1:0]   data_mem [2][SETS];
  logic [TAG_W-1:0]    tag_rd   [2];
  logic [DATA_W-1:0]   data_rd  [2];

  logic [IDX_W-1:0]    req_idx, rd_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit0, hit1, victim, fill_dropped;
  logic                hit_inc, miss_inc, fill_we, lru_we, lru_val;

  assign req_idx = req_addr_q[IDX_W-1:0];
  assign req_tag = req_addr_q[ADDR_W-1:IDX_W];
  // In IDLE the RAMs are addressed straight from the request so data lands by CMP.
  assign rd_idx  = (state_q == S_IDLE) ? cache_addr[IDX_W-1:0] : req_idx;

  assign hit0   = valid_q[0][req_idx] && (tag_rd[0] == req_tag);
  assign hit1   = valid_q[1][req_idx] && (tag_rd[1] == req_tag);
  assign victim = !valid_q[0][req_idx] ? 1'b0 :
                  !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  // A flush seen anywhere during the miss keeps the filled line invalid.
  assign fill_dropped = flush || flush_seen_q;

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[victim][req_idx]  <= req_tag;
      data_mem[victim][req_idx] <= rom_data;
    end
    tag_rd[0]  <= tag_mem[0][rd_idx];
    tag_rd[1]  <= tag_mem[1][rd_idx];
    data_rd[0] <= data_mem[0][rd_idx];
    data_rd[1] <= data_mem[1][rd_idx];
  end

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    cache_valid_d = cache_valid_q;
    cache_data_d  = cache_data_q;
    rom_req_d     = rom_req_q;
    rom_addr_d    = rom_addr_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    fill_we       = 1'b0;
    lru_we        = 1'b0;
    lru_val       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cache_req) begin
          req_addr_d = cache_addr;
          state_d    = S_RD;
        end
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        if (hit0 || hit1) begin
          cache_valid_d = 1'b1;
          cache_data_d  = hit0 ? data_rd[0] : data_rd[1];
          lru_we        = 1'b1;
          lru_val       = hit0;
          hit_inc       = 1'b1;
          state_d       = S_DONE;
        end else begin
          rom_req_d  = 1'b1;
          rom_addr_d = req_addr_q;
          miss_inc   = 1'b1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (rom_valid) begin
          rom_req_d     = 1'b0;
          cache_valid_d = 1'b1;
          cache_data_d  = rom_data;
          fill_we       = 1'b1;
          lru_we        = !fill_dropped;
          lru_val       = ~victim;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (!(cache_req && (cache_addr == req_addr_q))) begin
          cache_valid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_addr_q    <= '0;
      cache_valid_q <= 1'b0;
      cache_data_q  <= '0;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      flush_seen_q  <= 1'b0;
      valid_q[0]    <= '0;
      valid_q[1]    <= '0;
      lru_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      cache_valid_q <= cache_valid_d;
      cache_data_q  <= cache_data_d;
      rom_req_q     <= rom_req_d;
      rom_addr_q    <= rom_addr_d;
      flush_seen_q  <= flush || (flush_seen_q && (state_q == S_FILL));
      if (flush) begin
        valid_q[0] <= '0;
        valid_q[1] <= '0;
        lru_q      <= '0;
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else begin
        if (fill_we && !fill_dropped) valid_q[victim][req_idx] <= 1'b1;
        if (lru_we) lru_q[req_idx] <= lru_val;
        if (hit_inc && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign cache_valid = cache_valid_q;
  assign cache_data  = cache_data_q;
  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tile_cache_2way.sv
// Directed bench for tile_cache_2way: vector table for hit/miss/LRU behaviour,
// hand-written sequences for flush, reset during fill and counter saturation.
module tb_tile_cache_2way;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 10;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              cache_req;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_valid;
  logic [DATA_W-1:0] cache_data;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rom_valid;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  logic [2:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  tile_cache_2way #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .cache_req(cache_req), .cache_addr(cache_addr),
    .cache_valid(cache_valid), .cache_data(cache_data),
    .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_valid(rom_valid),
    .hit_count(hit_count), .miss_count(miss_count),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One request: ROM answers rom_word after 'delay' cycles of rom_req; flush pulses
  // in cycle flush_at (0 = none); the request is held 'hold' extra cycles after valid.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rom_word,
                         input int delay, input int hold, input int flush_at,
                         output logic [DATA_W-1:0] data, output bit missed, output int lat);
    int rom_cnt;
    bit done;
    missed = 1'b0; lat = 0; done = 1'b0; rom_cnt = 0; data = '0;
    cache_addr = addr;
    cache_req  = 1'b1;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(posedge clk); #1;
      rom_valid = 1'b0;
      flush     = (cyc == flush_at);
      if (rom_req) begin
        if (!missed) begin
          missed = 1'b1;
          check("rom_addr", 32'(rom_addr), 32'(addr));
        end
        rom_cnt++;
        if (rom_cnt == delay) begin
          rom_valid = 1'b1;
          rom_data  = rom_word;
        end
      end
      if (cache_valid) begin
        data = cache_data;
        lat  = cyc;
        done = 1'b1;
      end
    end
    flush     = 1'b0;
    rom_valid = 1'b0;
    check("request completes", 32'(done), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("valid held", 32'(cache_valid), 32'd1);
    end
    cache_req = 1'b0;
    @(posedge clk); #1;
    check("valid drops", 32'(cache_valid), 32'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rom_word;
    int                delay;
    int                hold;
    bit                exp_miss;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  logic [DATA_W-1:0] got;
  bit                missed;
  int                lat;
  int                exp_hits;
  int                exp_misses;
  logic [CNT_W-1:0]  sat_val;

  initial begin
    // set 0x123 holds tags 0/1/2 (0x00123/0x00523/0x00923); LRU decides evictions
    vec[0]  = '{20'h00123, 32'hDEADBEEF, 5, 0, 1'b1, 32'hDEADBEEF};
    vec[1]  = '{20'h00123, 32'hBAD00001, 1, 2, 1'b0, 32'hDEADBEEF};
    vec[2]  = '{20'h00523, 32'h11110523, 3, 0, 1'b1, 32'h11110523};
    vec[3]  = '{20'h00923, 32'h22220923, 1, 0, 1'b1, 32'h22220923};
    vec[4]  = '{20'h00123, 32'h33330123, 2, 1, 1'b1, 32'h33330123};
    vec[5]  = '{20'h00923, 32'hBAD00002, 1, 0, 1'b0, 32'h22220923};
    vec[6]  = '{20'h00523, 32'h44440523, 4, 0, 1'b1, 32'h44440523};
    vec[7]  = '{20'h00456, 32'h55550456, 1, 0, 1'b1, 32'h55550456};
    vec[8]  = '{20'h00456, 32'hBAD00003, 1, 0, 1'b0, 32'h55550456};
    vec[9]  = '{20'h00923, 32'hBAD00004, 1, 0, 1'b0, 32'h22220923};
    vec[10] = '{20'hFFFFF, 32'hCAFEF00D, 2, 0, 1'b1, 32'hCAFEF00D};
    vec[11] = '{20'hFFFFF, 32'hBAD00005, 1, 1, 1'b0, 32'hCAFEF00D};
    vec[12] = '{20'h00000, 32'h0000ABCD, 1, 0, 1'b1, 32'h0000ABCD};
    vec[13] = '{20'h00000, 32'hBAD00006, 1, 0, 1'b0, 32'h0000ABCD};
    vec[14] = '{20'h00523, 32'hBAD00007, 1, 0, 1'b0, 32'h44440523};

    // reset
    reset = 1'b1; flush = 1'b0; cache_req = 1'b0; cache_addr = '0;
    rom_data = '0; rom_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset cache_valid", 32'(cache_valid), 32'd0);
    check("reset cache_data", cache_data, 32'd0);
    check("reset rom_req", 32'(rom_req), 32'd0);
    check("reset rom_addr", 32'(rom_addr), 32'd0);
    check("reset hit_count", 32'(hit_count), 32'd0);
    check("reset miss_count", 32'(miss_count), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // table-driven hit/miss/LRU vectors
    exp_hits = 0; exp_misses = 0;
    for (int i = 0; i < NV; i++) begin
      do_read(vec[i].addr, vec[i].rom_word, vec[i].delay, vec[i].hold, 0, got, missed, lat);
      if (vec[i].exp_miss) exp_misses++;
      else exp_hits++;
      check($sformatf("v%0d data", i), got, vec[i].exp_data);
      check($sformatf("v%0d miss", i), 32'(missed), 32'(vec[i].exp_miss));
      if (!vec[i].exp_miss) check($sformatf("v%0d hit latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d hit_count", i), 32'(hit_count), 32'(exp_hits));
      check($sformatf("v%0d miss_count", i), 32'(miss_count), 32'(exp_misses));
    end

    // flush while idle, then fill / hit / flush / miss
    pulse_flush();
    check("flush hit_count", 32'(hit_count), 32'd0);
    check("flush miss_count", 32'(miss_count), 32'd0);
    do_read(20'h00123, 32'h66660123, 3, 0, 0, got, missed, lat);
    check("f1 miss", 32'(missed), 32'd1);
    do_read(20'h00123, 32'hBAD00010, 1, 0, 0, got, missed, lat);
    check("f2 hit", 32'(missed), 32'd0);
    check("f2 data", got, 32'h66660123);
    pulse_flush();
    do_read(20'h00123, 32'h77770123, 2, 0, 0, got, missed, lat);
    check("f3 miss after flush", 32'(missed), 32'd1);
    check("f3 data", got, 32'h77770123);
    check("f3 hit_count", 32'(hit_count), 32'd0);
    check("f3 miss_count", 32'(miss_count), 32'd1);

    // flush during FILL: data still returned, line stays invalid, counters cleared
    do_read(20'h00777, 32'h88880777, 5, 0, 4, got, missed, lat);
    check("ff data", got, 32'h88880777);
    check("ff hit_count", 32'(hit_count), 32'd0);
    check("ff miss_count", 32'(miss_count), 32'd0);
    do_read(20'h00777, 32'h99990777, 2, 0, 0, got, missed, lat);
    check("ff reread miss", 32'(missed), 32'd1);
    check("ff reread data", got, 32'h99990777);
    do_read(20'h00777, 32'hBAD00011, 1, 0, 0, got, missed, lat);
    check("ff third hit", 32'(missed), 32'd0);
    check("ff third data", got, 32'h99990777);

    // flush on the same edge as the fill completes
    do_read(20'h00ABC, 32'hAAAA0ABC, 5, 0, 7, got, missed, lat);
    check("fs data", got, 32'hAAAA0ABC);
    check("fs miss_count", 32'(miss_count), 32'd0);
    do_read(20'h00ABC, 32'hBBBB0ABC, 1, 0, 0, got, missed, lat);
    check("fs reread miss", 32'(missed), 32'd1);
    check("fs reread data", got, 32'hBBBB0ABC);
    check("fs miss_count2", 32'(miss_count), 32'd1);

    // asynchronous reset while waiting on the ROM
    cache_addr = 20'h00888;
    cache_req  = 1'b1;
    for (int c = 0; c < 20 && !rom_req; c++) begin
      @(posedge clk); #1;
    end
    check("rst rom_req reached", 32'(rom_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst rom_req drop", 32'(rom_req), 32'd0);
    check("rst cache_valid", 32'(cache_valid), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    cache_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    rom_valid = 1'b1;
    rom_data  = 32'hDDDD0888;
    @(posedge clk); #1;
    rom_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rst late rom_valid ignored", 32'(cache_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("rst miss_count", 32'(miss_count), 32'd0);
    do_read(20'h00888, 32'hEEEE0888, 2, 0, 0, got, missed, lat);
    check("rst reread miss", 32'(missed), 32'd1);
    check("rst reread data", got, 32'hEEEE0888);

    // hit counter saturation
    sat_val = '1;
    for (int k = 0; k < int'(sat_val); k++)
      do_read(20'h00888, 32'hBAD00012, 1, 0, 0, got, missed, lat);
    check("sat hit_count full", 32'(hit_count), 32'(sat_val));
    do_read(20'h00888, 32'hBAD00013, 1, 0, 0, got, missed, lat);
    check("sat extra hit", 32'(missed), 32'd0);
    check("sat data", got, 32'hEEEE0888);
    check("sat hit_count held", 32'(hit_count), 32'(sat_val));
    check("sat miss_count", 32'(miss_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
